// File: rtl/rtc_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rtc_bus_pkg                                                |
// | Description : State encoding and default timing for the RTC multiplexed  |
// |               address/data bus sequencer.                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package rtc_bus_pkg;

  // Sequencer states, in the order a transaction walks through them
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_A_SETUP  = 4'd1,
    ST_A_STROBE = 4'd2,
    ST_A_HOLD   = 4'd3,
    ST_GAP      = 4'd4,
    ST_D_SETUP  = 4'd5,
    ST_D_STROBE = 4'd6,
    ST_D_HOLD   = 4'd7,
    ST_DONE     = 4'd8
  } state_t;

  // Default bus width and phase timing (in clock cycles)
  localparam int c_DEF_DW         = 8;
  localparam int c_DEF_SETUP      = 1;
  localparam int c_DEF_ADDR_PULSE = 6;
  localparam int c_DEF_DATA_PULSE = 6;
  localparam int c_DEF_HOLD       = 1;
  localparam int c_DEF_GAP        = 4;
  localparam int c_DEF_CNT_W      = 5;

endpackage
`default_nettype wire

// File: rtl/rtc_phase_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rtc_phase_timer                                            |
// | Description : Loadable down-counter timing one sequencer phase. The      |
// |               expire flag is high while the count equals 1, i.e. in the  |
// |               last cycle of the loaded duration.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rtc_phase_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load a new phase length, otherwise count down and rest at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire_o = (cnt_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/rtc_bus_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rtc_bus_seq                                                |
// | Description : Sequencer for an RTC multiplexed address/data bus. Runs an |
// |               address phase then a data phase (write or read), with all  |
// |               outputs registered for glitch-free strobes.                |
// |               Optional macro RTC_BUS_SEQ_RUNTIME_PULSE_EN adds input     |
// |               cfg_pulse which, sampled with start, sets both strobe      |
// |               widths (0 is treated as 1).                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rtc_bus_seq
  import rtc_bus_pkg::*;
#(
  parameter int DW         = c_DEF_DW,
  parameter int SETUP      = c_DEF_SETUP,
  parameter int ADDR_PULSE = c_DEF_ADDR_PULSE,
  parameter int DATA_PULSE = c_DEF_DATA_PULSE,
  parameter int HOLD       = c_DEF_HOLD,
  parameter int GAP        = c_DEF_GAP,
  parameter int CNT_W      = c_DEF_CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          wr_en,
  input  logic [DW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] bus_in,
  output logic [DW-1:0] bus_out,
  output logic          bus_oe,
  output logic          ad,
  output logic          cs_n,
  output logic          wr_n,
  output logic          rd_n,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid
`ifdef RTC_BUS_SEQ_RUNTIME_PULSE_EN
  ,
  input  logic [CNT_W-1:0] cfg_pulse
`endif
);

  state_t           state_q, state_d;
  logic             wr_q, wr_d;
  logic [DW-1:0]    addr_q, addr_d, wdata_q, wdata_d;
  logic [DW-1:0]    bus_out_q, bus_out_d, rdata_q;
  logic             bus_oe_q, bus_oe_d, ad_q, ad_d;
  logic             cs_n_q, cs_n_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
  logic             busy_q, busy_d, done_q, done_d, rvalid_q, rvalid_d;
  logic             w_load, w_expire, w_accept;
  logic [CNT_W-1:0] w_load_val, w_a_pulse, w_d_pulse;

  // A request is only honoured while idle; anything else is dropped
  assign w_accept = (state_q == ST_IDLE) && start;

  // Transaction fields are visible to the output logic in the accept cycle
  assign wr_d    = w_accept ? wr_en : wr_q;
  assign addr_d  = w_accept ? addr  : addr_q;
  assign wdata_d = w_accept ? wdata : wdata_q;

`ifdef RTC_BUS_SEQ_RUNTIME_PULSE_EN
  logic [CNT_W-1:0] pulse_q;

  // Latch the run-time strobe width at accept, promoting 0 to 1
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_q <= CNT_W'(ADDR_PULSE);
    end else if (w_accept) begin
      pulse_q <= (cfg_pulse == '0) ? CNT_W'(1) : cfg_pulse;
    end
  end

  assign w_a_pulse = pulse_q;
  assign w_d_pulse = pulse_q;
`else
  assign w_a_pulse = CNT_W'(ADDR_PULSE);
  assign w_d_pulse = CNT_W'(DATA_PULSE);
`endif

  rtc_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (w_load),
    .load_val_i (w_load_val),
    .expire_o   (w_expire)
  );

  // Next state: each timed phase advances when its timer expires and loads the next length
  always_comb begin
    state_d    = state_q;
    w_load     = 1'b0;
    w_load_val = '0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_A_SETUP;  w_load = 1'b1; w_load_val = CNT_W'(SETUP);
      end
      ST_A_SETUP: if (w_expire) begin
        state_d = ST_A_STROBE; w_load = 1'b1; w_load_val = w_a_pulse;
      end
      ST_A_STROBE: if (w_expire) begin
        state_d = ST_A_HOLD;   w_load = 1'b1; w_load_val = CNT_W'(HOLD);
      end
      ST_A_HOLD: if (w_expire) begin
        w_load = 1'b1;
        if (GAP != 0) begin
          state_d = ST_GAP;     w_load_val = CNT_W'(GAP);
        end else begin
          state_d = ST_D_SETUP; w_load_val = CNT_W'(SETUP);
        end
      end
      ST_GAP: if (w_expire) begin
        state_d = ST_D_SETUP;  w_load = 1'b1; w_load_val = CNT_W'(SETUP);
      end
      ST_D_SETUP: if (w_expire) begin
        state_d = ST_D_STROBE; w_load = 1'b1; w_load_val = w_d_pulse;
      end
      ST_D_STROBE: if (w_expire) begin
        state_d = ST_D_HOLD;   w_load = 1'b1; w_load_val = CNT_W'(HOLD);
      end
      ST_D_HOLD: if (w_expire) state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with state_q
  always_comb begin
    ad_d      = 1'b1;
    cs_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    rd_n_d    = 1'b1;
    bus_oe_d  = 1'b0;
    bus_out_d = '0;
    busy_d    = (state_d != ST_IDLE);
    done_d    = 1'b0;
    rvalid_d  = 1'b0;
    case (state_d)
      ST_A_SETUP, ST_A_HOLD: begin
        ad_d = 1'b0; bus_oe_d = 1'b1; bus_out_d = addr_d;
      end
      ST_A_STROBE: begin
        ad_d = 1'b0; bus_oe_d = 1'b1; bus_out_d = addr_d;
        cs_n_d = 1'b0; wr_n_d = 1'b0;
      end
      ST_D_SETUP, ST_D_HOLD: begin
        bus_oe_d = wr_d; bus_out_d = wdata_d;
      end
      ST_D_STROBE: begin
        bus_oe_d = wr_d; bus_out_d = wdata_d; cs_n_d = 1'b0;
        if (wr_d) wr_n_d = 1'b0;
        else      rd_n_d = 1'b0;
      end
      ST_DONE: begin
        done_d = 1'b1; rvalid_d = !wr_d;
      end
      default: ;
    endcase
  end

  // State, transaction fields and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ad_q      <= 1'b1;
      cs_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      bus_oe_q  <= 1'b0;
      bus_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ad_q      <= ad_d;
      cs_n_q    <= cs_n_d;
      wr_n_q    <= wr_n_d;
      rd_n_q    <= rd_n_d;
      bus_oe_q  <= bus_oe_d;
      bus_out_q <= bus_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // Read data is captured at the edge closing the last read-strobe cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if ((state_q == ST_D_STROBE) && w_expire && !wr_q) begin
      rdata_q <= bus_in;
    end
  end

  assign bus_out     = bus_out_q;
  assign bus_oe      = bus_oe_q;
  assign ad          = ad_q;
  assign cs_n        = cs_n_q;
  assign wr_n        = wr_n_q;
  assign rd_n        = rd_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rtc_bus_seq                                             |
// | Description : Directed self-checking bench for rtc_bus_seq. Instance 0   |
// |               uses default timing, instance 1 has GAP=0; both see the    |
// |               same stimulus. Build with RTC_BUS_SEQ_RUNTIME_PULSE_EN to  |
// |               also exercise cfg_pulse.                                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_rtc_bus_seq;

  logic       clk = 1'b0;
  logic       reset, start, wr_en;
  logic [7:0] addr, wdata, rd_val;
  logic [7:0] bus_in [2], bus_out [2], rdata [2];
  logic       bus_oe [2], ad [2], cs_n [2], wr_n [2], rd_n [2];
  logic       busy [2], done [2], rdata_valid [2];
`ifdef RTC_BUS_SEQ_RUNTIME_PULSE_EN
  logic [4:0] cfg_pulse;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Per-instance statistics gathered over one observation window
  int         a_strb [2], d_wr [2], d_rd [2], wr_lo [2], bad [2];
  int         first_data [2], done_idx [2], done_cnt [2], rv_cnt [2];
  int         busy_cnt [2], busy0 [2];
  logic [7:0] rdata_at [2];
  int         rv_at [2];
  logic [7:0] cur_addr, cur_wdata;

  always #5 clk = ~clk;

  // Bus device model: drives the read value only while read strobe is low
  always_comb begin
    for (int u = 0; u < 2; u++) bus_in[u] = rd_n[u] ? 8'hFF : rd_val;
  end

  rtc_bus_seq u_dut0 (
    .clk(clk), .reset(reset), .start(start), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .bus_in(bus_in[0]), .bus_out(bus_out[0]), .bus_oe(bus_oe[0]), .ad(ad[0]),
    .cs_n(cs_n[0]), .wr_n(wr_n[0]), .rd_n(rd_n[0]), .busy(busy[0]), .done(done[0]),
    .rdata(rdata[0]), .rdata_valid(rdata_valid[0])
`ifdef RTC_BUS_SEQ_RUNTIME_PULSE_EN
    , .cfg_pulse(cfg_pulse)
`endif
  );

  rtc_bus_seq #(.GAP(0)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .bus_in(bus_in[1]), .bus_out(bus_out[1]), .bus_oe(bus_oe[1]), .ad(ad[1]),
    .cs_n(cs_n[1]), .wr_n(wr_n[1]), .rd_n(rd_n[1]), .busy(busy[1]), .done(done[1]),
    .rdata(rdata[1]), .rdata_valid(rdata_valid[1])
`ifdef RTC_BUS_SEQ_RUNTIME_PULSE_EN
    , .cfg_pulse(cfg_pulse)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand formula: setup+hold twice, two strobes, the gap; index counted from A_SETUP
  function automatic int exp_done(input int u, input int p);
    return 4 + 2 * p + ((u == 0) ? 4 : 0);
  endfunction

  task automatic begin_txn(input logic we, input logic [7:0] a, input logic [7:0] d);
    wr_en = we; addr = a; wdata = d;
    cur_addr = a; cur_wdata = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    addr = 8'h00; wdata = 8'h00; wr_en = ~we;
  endtask

  // Observe n_cyc cycles; sample index 0 is the cycle just after the accept edge
  task automatic watch(input int n_cyc, input int p0, input int p1);
    for (int u = 0; u < 2; u++) begin
      a_strb[u] = 0; d_wr[u] = 0; d_rd[u] = 0; wr_lo[u] = 0; bad[u] = 0;
      first_data[u] = -1; done_idx[u] = -1; done_cnt[u] = 0; rv_cnt[u] = 0;
      busy_cnt[u] = 0; busy0[u] = 0; rdata_at[u] = 8'h00; rv_at[u] = 0;
    end
    for (int n = 0; n < n_cyc; n++) begin
      start = (n == p0) || (n == p1);
      for (int u = 0; u < 2; u++) begin
        if (n == 0) busy0[u] = int'(busy[u]);
        if (busy[u]) busy_cnt[u]++;
        if (!wr_n[u]) wr_lo[u]++;
        if (!cs_n[u] && !wr_n[u] && !ad[u] && bus_oe[u] && bus_out[u] == cur_addr) a_strb[u]++;
        if (!cs_n[u] && !wr_n[u] && ad[u] && bus_oe[u] && bus_out[u] == cur_wdata) d_wr[u]++;
        if (!cs_n[u] && !rd_n[u] && ad[u] && !bus_oe[u]) d_rd[u]++;
        if ((!wr_n[u] && !rd_n[u]) || (cs_n[u] != (wr_n[u] & rd_n[u]))) bad[u]++;
        if (ad[u] && bus_oe[u] && first_data[u] < 0) first_data[u] = n;
        if (rdata_valid[u]) rv_cnt[u]++;
        if (done[u]) begin
          done_cnt[u]++;
          if (done_idx[u] < 0) begin
            done_idx[u] = n; rdata_at[u] = rdata[u]; rv_at[u] = int'(rdata_valid[u]);
          end
        end
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic check_write(input string nm, input int p);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("%s_busy%0d", nm, u), busy0[u], 1);
      chk($sformatf("%s_addr_strobe%0d", nm, u), a_strb[u], p);
      chk($sformatf("%s_data_strobe%0d", nm, u), d_wr[u], p);
      chk($sformatf("%s_rd_strobe%0d", nm, u), d_rd[u], 0);
      chk($sformatf("%s_strobe_rule%0d", nm, u), bad[u], 0);
      chk($sformatf("%s_first_data%0d", nm, u), first_data[u], exp_done(u, p) - p - 2);
      chk($sformatf("%s_done_idx%0d", nm, u), done_idx[u], exp_done(u, p));
      chk($sformatf("%s_done_cnt%0d", nm, u), done_cnt[u], 1);
      chk($sformatf("%s_rvalid_cnt%0d", nm, u), rv_cnt[u], 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; wr_en = 1'b0; addr = 8'h00; wdata = 8'h00; rd_val = 8'h00;
    cur_addr = 8'h00; cur_wdata = 8'h00;
`ifdef RTC_BUS_SEQ_RUNTIME_PULSE_EN
    cfg_pulse = 5'd6;
`endif
    repeat (3) tick();
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst_ctrl%0d", u),
          int'({ad[u], cs_n[u], wr_n[u], rd_n[u], bus_oe[u], busy[u], done[u], rdata_valid[u]}),
          8'hF0);
      chk($sformatf("rst_bus_out%0d", u), bus_out[u], 0);
      chk($sformatf("rst_rdata%0d", u), rdata[u], 0);
    end
    reset = 1'b0;
    tick();

    // Write 0x5A to address 0x21
    begin_txn(1'b1, 8'h21, 8'h5A);
    watch(30, -1, -1);
    check_write("wr", 6);

    // Read address 0x22, device returns 0x37
    rd_val = 8'h37;
    begin_txn(1'b0, 8'h22, 8'h00);
    watch(30, -1, -1);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rd_rd_strobe%0d", u), d_rd[u], 6);
      chk($sformatf("rd_wr_low%0d", u), wr_lo[u], 6);
      chk($sformatf("rd_data_drive%0d", u), first_data[u], -1);
      chk($sformatf("rd_strobe_rule%0d", u), bad[u], 0);
      chk($sformatf("rd_done_idx%0d", u), done_idx[u], exp_done(u, 6));
      chk($sformatf("rd_rdata%0d", u), rdata_at[u], 8'h37);
      chk($sformatf("rd_rvalid_with_done%0d", u), rv_at[u], 1);
      chk($sformatf("rd_rvalid_cnt%0d", u), rv_cnt[u], 1);
    end

    // Extra start pulses while busy must be dropped
    begin_txn(1'b1, 8'hC3, 8'h3C);
    watch(45, 3, 10);
    check_write("ign", 6);
    for (int u = 0; u < 2; u++)
      chk($sformatf("ign_rdata_hold%0d", u), rdata[u], 8'h37);

    // Reset in the middle of a read data strobe, with start asserted alongside
    rd_val = 8'h99;
    begin_txn(1'b0, 8'h44, 8'h00);
    watch(14, -1, -1);
    for (int u = 0; u < 2; u++)
      chk($sformatf("abort_in_strobe%0d", u), int'({cs_n[u], rd_n[u]}), 0);
    reset = 1'b1; start = 1'b1; wr_en = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("abort_ctrl%0d", u),
          int'({cs_n[u], wr_n[u], rd_n[u], bus_oe[u], busy[u], done[u], rdata_valid[u]}),
          7'b1110000);
      chk($sformatf("abort_rdata%0d", u), rdata[u], 0);
    end
    watch(30, -1, -1);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("abort_no_done%0d", u), done_cnt[u] + rv_cnt[u], 0);
      chk($sformatf("abort_no_busy%0d", u), busy_cnt[u], 0);
    end

`ifdef RTC_BUS_SEQ_RUNTIME_PULSE_EN
    cfg_pulse = 5'd0;
    begin_txn(1'b1, 8'h5A, 8'hA5);
    cfg_pulse = 5'd10;
    watch(30, -1, -1);
    check_write("cfg0", 1);
    begin_txn(1'b1, 8'h12, 8'h34);
    cfg_pulse = 5'd0;
    watch(40, -1, -1);
    check_write("cfg10", 10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
